slow_rate_bridge: RTL
=====================

# slow_rate_bridge

Rate-matching buffer between full-rate `clk` logic and stages that advance only on the one-in-four strobe from the clock divider. The fast side pushes words with a valid/ready handshake at any cycle rate. The slow side gets exactly one pop per strobe, into a registered output that holds steady for the whole slow period. It sits on the IF path, so instruction words fetched at core-clock rate are presented to divided-rate consumers without loss or duplication.

## Interface
- `DW`, 32, data word width
- `DEPTH_LOG2`, 2, log2 of FIFO depth (DEPTH = 2**DEPTH_LOG2 = 4 by default)
- `clk`  input  1  single clock; all state updates on posedge
- `rst`  input  1  reset; synchronous, active-high
- `in_valid`  input  1  fast-side word offered
- `in_data`  input  DW  fast-side word
- `in_ready`  output  1  FIFO can accept this cycle
- `stb`  input  1  slow-rate advance strobe (divider output)
- `out_valid`  output  1  `out_data` holds a real word for the current slow period
- `out_data`  output  DW  registered head word, stable between pops
- `fill`  output  DEPTH_LOG2+1  current FIFO occupancy, 0..DEPTH

## Operation
- Storage: circular buffer of DEPTH entries with `wptr`/`rptr`, each DEPTH_LOG2 bits and wrapping modulo DEPTH. Occupancy is the registered `fill` counter.
- `in_ready` = (`fill` != DEPTH). It is combinational from registered state only and never depends on `stb` or `in_valid`.
- Push: at a posedge with `in_valid & in_ready`, write `in_data` to `mem[wptr]` and increment `wptr`.
- Pop event `pop` is derived from `stb` (see Configuration).
- At a posedge with `pop` and `fill != 0`:
  - `out_data` <= `mem[rptr]`, `out_valid` <= 1, `rptr` increments.
- At a posedge with `pop` and `fill == 0` (underrun): `out_valid` <= 0 and `out_data` holds its old value.
- Without `pop`, `out_valid` and `out_data` hold.
- `fill` update: +1 on push only, -1 on successful pop only, unchanged on both or neither.
- Simultaneous push and pop with `fill == 0`:
  - The pushed word enters the FIFO.
  - The pop reports underrun (no write-to-output bypass).
  - `fill` becomes 1.
- Simultaneous push and pop with `fill == DEPTH`: push is blocked because `in_ready` = 0; the pop succeeds and `fill` becomes DEPTH-1.
- Data ordering is strictly FIFO. No word is dropped or presented twice.

## Timing
- Reset (`rst` = 1 at a posedge) values: `wptr` = 0, `rptr` = 0, `fill` = 0, `out_valid` = 0, `out_data` = 0, edge register = 0. `in_ready` is therefore 1 in the cycle after reset.
- Reset mid-operation discards all buffered words and any held output. `rst` dominates push and pop in the same cycle.
- Push latency: a word pushed at posedge N is poppable at any pop posedge at N+1 or later.
- Output latency: `out_data`/`out_valid` change only in the cycle after a pop posedge. With a 1-in-4 strobe they are stable for 4 cycles.
- Sustained throughput: slow side is 1 word per strobe. The fast side back-pressures via `in_ready` once DEPTH words are queued.
- `mem` is not reset; contents are don't-care until written.

## Configuration
- `SLOW_BRIDGE_STB_EDGE_EN` defined: `stb` is treated as a level.
  - An internal register `stb_d` <= `stb`, with reset value 0.
  - `pop` = `stb & ~stb_d`, so exactly one pop per rising edge however long `stb` stays high.
  - A `stb` already high in the first cycle after reset counts as a rising edge.
- Not defined: `pop` = `stb`. `stb` must be a one-cycle pulse, and every high cycle pops.

## Test plan
- Reset then idle: after `rst` deasserts, `in_ready` = 1, `fill` = 0, `out_valid` = 0, `out_data` = 0. A strobe on an empty FIFO keeps `out_valid` = 0.
- Ordered delivery: push 0x11, 0x22, 0x33 on consecutive cycles, then strobe every 4 cycles. `out_data` must show 0x11, 0x22, 0x33 on successive slow periods with `out_valid` = 1. A fourth strobe gives `out_valid` = 0 with `out_data` holding 0x33.
- Full/back-pressure: hold `in_valid` high with 0xA0..0xA5 and no strobe.
  - After 4 accepts, `fill` = 4 and `in_ready` = 0, while 0xA4 waits.
  - One strobe pops 0xA0 and `fill` = 3; `in_ready` = 1 the next cycle, then 0xA4 is accepted.
- Simultaneous push+pop at empty: push 0x5A in the same cycle as `stb`. Required: `out_valid` = 0 and `fill` = 1. The next strobe gives `out_data` = 0x5A.
- Reset mid-operation: with `fill` = 3 and `out_valid` = 1, assert `rst` for one cycle together with `stb` and `in_valid`. All state returns to reset values and the pushed word is not stored.
- Edge mode (macro defined): hold `stb` high for 6 cycles with `fill` = 2. Exactly one pop occurs and `fill` = 1. Without the macro the same stimulus pops twice, then underruns.

Source files
------------

// File: rtl/slow_rate_bridge.sv
// Rate-matching FIFO: full-rate pushes, one pop per slow strobe into a held output register.
// Optional macro SLOW_BRIDGE_STB_EDGE_EN treats stb as a level and pops on its rising edge.
module slow_rate_bridge #(
   parameter int DW         = 32,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DW-1:0]         in_data,
   output logic                  in_ready,
   input  logic                  stb,
   output logic                  out_valid,
   output logic [DW-1:0]         out_data,
   output logic [DEPTH_LOG2:0]   fill
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);

   logic [DW-1:0]         mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wptr;
   logic [DEPTH_LOG2-1:0] rptr;
   logic                  pop;
   logic                  push;
   logic                  pop_ok;

`ifdef SLOW_BRIDGE_STB_EDGE_EN
   logic stb_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         stb_d <= 1'b0;
      end else begin
         stb_d <= stb;
      end
   end

   assign pop = stb & ~stb_d;
`else
   assign pop = stb;
`endif

   assign in_ready = (fill != FULL);
   assign push     = in_valid & in_ready;
   // An empty FIFO underruns even if a word is being pushed this same cycle.
   assign pop_ok   = pop & (fill != '0);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr      <= '0;
         rptr      <= '0;
         fill      <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (push) begin
            wptr <= wptr + 1'b1;
         end
         if (pop) begin
            out_valid <= pop_ok;
         end
         if (pop_ok) begin
            out_data <= mem[rptr];
            rptr     <= rptr + 1'b1;
         end
         case ({push, pop_ok})
            2'b10:   fill <= fill + 1'b1;
            2'b01:   fill <= fill - 1'b1;
            default: fill <= fill;
         endcase
      end
   end

endmodule
